// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, instruction classes, state encoding
// and IR field positions shared by the control sequencer files.
package control_sequencer_pkg;

  localparam int IR_W     = 32;
  localparam int OPC_BITS = 5;
  localparam int IDX_W    = 4;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef logic [OPC_BITS-1:0] opc_t;

  localparam opc_t OP_ADD  = 5'b00011;
  localparam opc_t OP_SUB  = 5'b00100;
  localparam opc_t OP_AND  = 5'b00101;
  localparam opc_t OP_OR   = 5'b00110;
  localparam opc_t OP_SHR  = 5'b00111;
  localparam opc_t OP_SHRA = 5'b01000;
  localparam opc_t OP_SHL  = 5'b01001;
  localparam opc_t OP_ROR  = 5'b01010;
  localparam opc_t OP_ROL  = 5'b01011;
  localparam opc_t OP_MUL  = 5'b01111;
  localparam opc_t OP_DIV  = 5'b10000;
  localparam opc_t OP_NEG  = 5'b10001;
  localparam opc_t OP_NOT  = 5'b10010;
  localparam opc_t OP_NOP  = 5'b11010;
  localparam opc_t OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU3,
    C_ALU2,
    C_MULDIV,
    C_NOP,
    C_HALT,
    C_ILLEGAL
  } cls_e;

  function automatic cls_e op_class(input opc_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        op_class = C_ALU3;
      OP_NEG, OP_NOT:
        op_class = C_ALU2;
      OP_MUL, OP_DIV:
        op_class = C_MULDIV;
      OP_NOP:
        op_class = C_NOP;
      OP_HALT:
        op_class = C_HALT;
      default:
        op_class = C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// reg_select: register index to NUM_REGS one-hot decode.
// idx_i in, onehot_o out, oor_o high when idx_i >= N (onehot_o = 0).
module reg_select
  import control_sequencer_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [N-1:0]     onehot_o,
  output logic             oor_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = (idx_i == IDX_W'(i));
    end
    oor_o = ~|onehot_o;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute control FSM.
// Ports: clock/clear(sync, low), start/stop/mem_ready/ir in;
// datapath strobes, Rin/Rout one-hot, opcode, status and count out.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int COUNT_W  = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                stop,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowin,
  output logic                Zhighin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    opcode,
  output logic                run_status,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [COUNT_W-1:0]  instr_count
);

  state_e               state_q, state_d;
  logic                 stop_q, stop_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  opc_t                 opc;
  cls_e                 cls;
  logic [NUM_REGS-1:0]  ra_oh, rb_oh, rc_oh;
  logic                 ra_oor, rb_oor, rc_oor;
  logic                 bad_reg;
  logic                 illegal;
  logic                 unused_ir;

  assign opc       = ir[OPC_MSB:OPC_LSB];
  assign cls       = op_class(opc);
  assign unused_ir = ^ir[RC_LSB-1:0];

  reg_select #(.N(NUM_REGS)) u_ra (
    .idx_i    (ir[RA_MSB:RA_LSB]),
    .onehot_o (ra_oh),
    .oor_o    (ra_oor)
  );

  reg_select #(.N(NUM_REGS)) u_rb (
    .idx_i    (ir[RB_MSB:RB_LSB]),
    .onehot_o (rb_oh),
    .oor_o    (rb_oor)
  );

  reg_select #(.N(NUM_REGS)) u_rc (
    .idx_i    (ir[RC_MSB:RC_LSB]),
    .onehot_o (rc_oh),
    .oor_o    (rc_oor)
  );

  // Only the fields a class actually uses can make it illegal.
  always_comb begin
    bad_reg = 1'b0;
    unique case (cls)
      C_ALU3:           bad_reg = ra_oor | rb_oor | rc_oor;
      C_ALU2, C_MULDIV: bad_reg = ra_oor | rb_oor;
      default:          bad_reg = 1'b0;
    endcase
  end

  assign illegal = (cls == C_ILLEGAL) | bad_reg;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stop_d     = stop_q;
    cnt_d      = cnt_q;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Zhighin    = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    Rin        = '0;
    Rout       = '0;
    opcode     = '0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    run_status = !(state_q inside {S_IDLE, S_HALT});

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) state_d = S_T0;
      end
      S_HALT: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zlowin  = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (illegal) begin
          illegal_op = 1'b1;
          state_d    = S_T0;
        end else begin
          unique case (cls)
            C_ALU3: begin
              Rout    = rb_oh;
              Yin     = 1'b1;
              state_d = S_T4;
            end
            C_ALU2: begin
              Rout    = rb_oh;
              Zlowin  = 1'b1;
              opcode  = OPC_W'(opc);
              state_d = S_T4;
            end
            C_MULDIV: begin
              Rout    = ra_oh;
              Yin     = 1'b1;
              state_d = S_T4;
            end
            C_NOP: begin
              instr_done = 1'b1;
            end
            C_HALT: begin
              instr_done = 1'b1;
              state_d    = S_HALT;
            end
            default: state_d = S_T0;
          endcase
        end
      end
      S_T4: begin
        unique case (cls)
          C_ALU3: begin
            Rout    = rc_oh;
            Zlowin  = 1'b1;
            opcode  = OPC_W'(opc);
            state_d = S_T5;
          end
          C_ALU2: begin
            Zlowout    = 1'b1;
            Rin        = ra_oh;
            instr_done = 1'b1;
          end
          C_MULDIV: begin
            Rout    = rb_oh;
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
            opcode  = OPC_W'(opc);
            state_d = S_T5;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        unique case (cls)
          C_ALU3: begin
            Zlowout    = 1'b1;
            Rin        = ra_oh;
            instr_done = 1'b1;
          end
          C_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
            state_d = S_T6;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A stop seen in the retiring cycle itself also ends the run.
    if (instr_done) begin
      cnt_d  = cnt_q + COUNT_W'(1);
      stop_d = 1'b0;
      if (state_d != S_HALT) begin
        state_d = (stop_q || stop) ? S_IDLE : S_T0;
      end
    end else if (run_status && stop) begin
      stop_d = 1'b1;
    end
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed, table-driven check of control_sequencer
// plus hand sequences for latency and mid-wait clear.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;

  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic        run_status, illegal_op, instr_done;
  logic [15:0] instr_count;

  control_sequencer #(
    .NUM_REGS (16),
    .OPC_W    (5),
    .COUNT_W  (16)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .stop        (stop),
    .mem_ready   (mem_ready),
    .ir          (ir),
    .PCout       (PCout),
    .MARin       (MARin),
    .IncPC       (IncPC),
    .PCin        (PCin),
    .Read        (Read),
    .MDRin       (MDRin),
    .MDRout      (MDRout),
    .IRin        (IRin),
    .Yin         (Yin),
    .Zlowin      (Zlowin),
    .Zhighin     (Zhighin),
    .Zlowout     (Zlowout),
    .Zhighout    (Zhighout),
    .LOin        (LOin),
    .HIin        (HIin),
    .Rin         (Rin),
    .Rout        (Rout),
    .opcode      (opcode),
    .run_status  (run_status),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  localparam logic [14:0] B_PCOUT  = 15'h4000;
  localparam logic [14:0] B_MARIN  = 15'h2000;
  localparam logic [14:0] B_INCPC  = 15'h1000;
  localparam logic [14:0] B_PCIN   = 15'h0800;
  localparam logic [14:0] B_READ   = 15'h0400;
  localparam logic [14:0] B_MDRIN  = 15'h0200;
  localparam logic [14:0] B_MDROUT = 15'h0100;
  localparam logic [14:0] B_IRIN   = 15'h0080;
  localparam logic [14:0] B_YIN    = 15'h0040;
  localparam logic [14:0] B_ZLIN   = 15'h0020;
  localparam logic [14:0] B_ZHIN   = 15'h0010;
  localparam logic [14:0] B_ZLOUT  = 15'h0008;
  localparam logic [14:0] B_ZHOUT  = 15'h0004;
  localparam logic [14:0] B_LOIN   = 15'h0002;
  localparam logic [14:0] B_HIIN   = 15'h0001;

  localparam logic [14:0] T0S = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
  localparam logic [14:0] T1S = B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [14:0] T2S = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_MUL  = 32'h7A280000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_NEG  = 32'h8B380000;

  typedef struct {
    logic        clr, st, sp, mr;
    logic [31:0] ir;
    logic [14:0] stb;
    logic [15:0] rin, rout;
    logic [4:0]  opc;
    logic        run, ill, done;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(
    input logic clr, st, sp, mr, input logic [31:0] w,
    input logic [14:0] stb, input logic [15:0] rin, rout,
    input logic [4:0] opc, input logic run, ill, done,
    input logic [15:0] cnt);
    vec_t v;
    v.clr = clr; v.st = st; v.sp = sp; v.mr = mr; v.ir = w;
    v.stb = stb; v.rin = rin; v.rout = rout; v.opc = opc;
    v.run = run; v.ill = ill; v.done = done; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input vec_t e);
    logic [70:0] act, exp;
    act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
           Rin, Rout, opcode, run_status, illegal_op, instr_done,
           instr_count};
    exp = {e.stb, e.rin, e.rout, e.opc, e.run, e.ill, e.done, e.cnt};
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic latency(input logic [31:0] w, input int want,
                         input string nm);
    int n;
    @(negedge clock);
    clear = 1'b1; start = 1'b1; stop = 1'b0;
    mem_ready = 1'b1; ir = w;
    @(negedge clock);
    start = 1'b0; stop = 1'b1;
    n = 0;
    while (n < 30) begin
      #1;
      n++;
      if (instr_done) break;
      @(negedge clock);
      stop = 1'b0;
    end
    applied++;
    if (!instr_done || n != want) begin
      miscompares++;
      $display("FAIL %s: got %0d cycles (done=%b) want %0d",
               nm, n, instr_done, want);
    end
    @(negedge clock);
    stop = 1'b0;
  endtask

  initial begin
    // clr st sp mr ir | strobes rin rout opc run ill done cnt
    tbl.push_back(mk(0,0,0,0,IR_AND, 0,0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,1,IR_AND, 0,0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,1,IR_AND, T0S,0,0,0, 1,0,0, 0));
    tbl.push_back(mk(1,0,0,1,IR_AND, T1S,0,0,0, 1,0,0, 0));
    tbl.push_back(mk(1,0,0,1,IR_AND, T2S,0,0,0, 1,0,0, 0));
    tbl.push_back(mk(1,0,0,1,IR_AND, B_YIN,0,16'h0004,0, 1,0,0, 0));
    tbl.push_back(mk(1,0,0,1,IR_AND, B_ZLIN,0,16'h0008,5'b00101, 1,0,0, 0));
    tbl.push_back(mk(1,0,0,1,IR_AND, B_ZLOUT,16'h0002,0,0, 1,0,1, 0));
    tbl.push_back(mk(1,0,0,1,IR_MUL, T0S,0,0,0, 1,0,0, 1));
    tbl.push_back(mk(1,0,1,1,IR_MUL, T1S,0,0,0, 1,0,0, 1));
    tbl.push_back(mk(1,0,0,1,IR_MUL, T2S,0,0,0, 1,0,0, 1));
    tbl.push_back(mk(1,0,0,1,IR_MUL, B_YIN,0,16'h0010,0, 1,0,0, 1));
    tbl.push_back(mk(1,0,0,1,IR_MUL, B_ZLIN|B_ZHIN,0,16'h0020,5'b01111,
                     1,0,0, 1));
    tbl.push_back(mk(1,0,0,1,IR_MUL, B_ZLOUT|B_LOIN,0,0,0, 1,0,0, 1));
    tbl.push_back(mk(1,0,0,1,IR_MUL, B_ZHOUT|B_HIIN,0,0,0, 1,0,1, 1));
    tbl.push_back(mk(1,0,0,1,IR_MUL, 0,0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,1,1,1,IR_MUL, 0,0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,1,0,1,IR_NOP, 0,0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,0,0,1,IR_NOP, T0S,0,0,0, 1,0,0, 2));
    tbl.push_back(mk(1,0,0,0,IR_NOP, T1S,0,0,0, 1,0,0, 2));
    tbl.push_back(mk(1,0,0,0,IR_NOP, T1S,0,0,0, 1,0,0, 2));
    tbl.push_back(mk(1,0,0,0,IR_NOP, T1S,0,0,0, 1,0,0, 2));
    tbl.push_back(mk(1,0,0,1,IR_NOP, T1S,0,0,0, 1,0,0, 2));
    tbl.push_back(mk(1,0,0,1,IR_NOP, T2S,0,0,0, 1,0,0, 2));
    tbl.push_back(mk(1,0,0,1,IR_NOP, 0,0,0,0, 1,0,1, 2));
    tbl.push_back(mk(1,0,0,1,IR_BAD, T0S,0,0,0, 1,0,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_BAD, T1S,0,0,0, 1,0,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_BAD, T2S,0,0,0, 1,0,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_BAD, 0,0,0,0, 1,1,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_HALT, T0S,0,0,0, 1,0,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_HALT, T1S,0,0,0, 1,0,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_HALT, T2S,0,0,0, 1,0,0, 3));
    tbl.push_back(mk(1,0,0,1,IR_HALT, 0,0,0,0, 1,0,1, 3));
    tbl.push_back(mk(1,0,0,1,IR_HALT, 0,0,0,0, 0,0,0, 4));
    tbl.push_back(mk(1,1,0,1,IR_HALT, 0,0,0,0, 0,0,0, 4));
    tbl.push_back(mk(1,0,0,1,IR_NEG, T0S,0,0,0, 1,0,0, 4));
    tbl.push_back(mk(1,0,0,1,IR_NEG, T1S,0,0,0, 1,0,0, 4));
    tbl.push_back(mk(1,0,0,1,IR_NEG, T2S,0,0,0, 1,0,0, 4));
    tbl.push_back(mk(1,0,0,1,IR_NEG, B_ZLIN,0,16'h0080,5'b10001,
                     1,0,0, 4));
    tbl.push_back(mk(1,0,0,1,IR_NEG, B_ZLOUT,16'h0040,0,0, 1,0,1, 4));
    tbl.push_back(mk(1,0,0,1,IR_AND, T0S,0,0,0, 1,0,0, 5));
    tbl.push_back(mk(1,0,0,1,IR_AND, T1S,0,0,0, 1,0,0, 5));
    tbl.push_back(mk(1,0,0,1,IR_AND, T2S,0,0,0, 1,0,0, 5));
    tbl.push_back(mk(1,0,0,1,IR_AND, B_YIN,0,16'h0004,0, 1,0,0, 5));
    tbl.push_back(mk(0,0,0,1,IR_AND, B_ZLIN,0,16'h0008,5'b00101,
                     1,0,0, 5));
    tbl.push_back(mk(1,0,0,1,IR_AND, 0,0,0,0, 0,0,0, 0));

    clear = 1'b0;
    repeat (2) @(posedge clock);

    foreach (tbl[i]) begin
      @(negedge clock);
      clear = tbl[i].clr;
      start = tbl[i].st;
      stop = tbl[i].sp;
      mem_ready = tbl[i].mr;
      ir = tbl[i].ir;
      #1;
      check($sformatf("vec%0d", i), tbl[i]);
    end

    latency(IR_NOP, 4, "lat_nop");
    latency(IR_AND, 6, "lat_alu3");
    latency(IR_NEG, 5, "lat_alu2");
    latency(IR_MUL, 7, "lat_muldiv");

    // Clear while T1 is waiting on memory.
    @(negedge clock);
    clear = 1'b1; start = 1'b1; stop = 1'b0;
    mem_ready = 1'b0; ir = IR_AND;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #1;
    check("wait_t1", mk(1,0,0,0,IR_AND, T1S,0,0,0, 1,0,0, 4));
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("wait_t1_clr", mk(0,0,0,0,IR_AND, T1S,0,0,0, 1,0,0, 4));
    @(negedge clock);
    clear = 1'b1; mem_ready = 1'b1;
    #1;
    check("clr_idle", mk(1,0,0,1,IR_AND, 0,0,0,0, 0,0,0, 0));
    @(negedge clock);
    #1;
    check("clr_stay", mk(1,0,0,1,IR_AND, 0,0,0,0, 0,0,0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
